tap_read_arbiter: RTL
=====================

# tap_read_arbiter

Sequencing stage directly upstream of the TAP read interconnect. It accepts read commands (target address) from the UART command decoder, performs the ready/valid read handshake against the interconnect, captures the returned word, and serialises it as a framed byte stream (header byte, then data bytes LSB-first) to the UART transmitter. It also owns timeout handling for slow or absent peripherals.

## Interface
- READ_WIDTH, 32: width of the read data word; NB = ceil(READ_WIDTH/8) data bytes per response.
- TIMEOUT_CYCLES, 1024: maximum READ_VALID_I wait in cycles; used only when timeout is compiled in; must be ≥1.
- Constraint: IRLENGTH (uart_pkg) ≤ 7.
- CLK_I  in  1  clock; all logic on the rising edge.
- RST_I  in  1  synchronous, active-high reset.
- CMD_VALID_I  in  1  command decoder presents a read request.
- CMD_READY_O  out  1  arbiter accepts a command this cycle.
- CMD_ADDR_I  in  IRLENGTH  address of the register to read.
- READ_ADDRESS_O  out  IRLENGTH  address presented to the interconnect.
- READ_READY_O  out  1  read request/ready to the interconnect.
- READ_VALID_I  in  1  interconnect data valid.
- READ_DATA_I  in  READ_WIDTH  interconnect read data.
- TX_DATA_O  out  8  byte to UART transmitter.
- TX_VALID_O  out  1  TX_DATA_O valid.
- TX_READY_I  in  1  transmitter accepts the byte.
- BUSY_O  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, READ, SEND.
- IDLE: CMD_READY_O=1. When CMD_VALID_I=1: latch CMD_ADDR_I into READ_ADDRESS_O, clear the timeout counter and error flag, go to READ.
- READ: READ_READY_O=1, READ_ADDRESS_O stable. In a cycle with READ_VALID_I=1, capture READ_DATA_I into the shift register, build header, go to SEND.
- Header byte: bit7 = error flag; bits[6:IRLENGTH] = 0; bits[IRLENGTH-1:0] = address.
- SEND: TX_VALID_O=1. Byte index 0 is the header; bytes 1..NB are data[8k-1:8k-8], LSB byte first. Bits beyond READ_WIDTH in the last byte are 0.
- Each TX_VALID_O && TX_READY_I advances the index. TX_DATA_O is held stable while TX_READY_I=0.
- After byte NB is accepted, go to IDLE.
- Commands arriving outside IDLE are not accepted; CMD_READY_O=0 applies backpressure.
- READ_DATA_I is ignored except in the capture cycle.
- Reset: synchronous and highest priority.
  - Reset values: state IDLE; CMD_READY_O=0, READ_READY_O=0, READ_ADDRESS_O=0, TX_VALID_O=0, TX_DATA_O=0, BUSY_O=0.
  - CMD_READY_O rises in the first cycle after RST_I drops.
  - Reset mid-READ or mid-SEND abandons the transaction; no further bytes are emitted.

## Timing
- All outputs are registered.
- Command accepted at cycle N (CMD_VALID_I && CMD_READY_O): READ_READY_O=1 and BUSY_O=1 from cycle N+1.
- READ_VALID_I=1 sampled at cycle M (M ≥ N+1): READ_READY_O=0 and TX_VALID_O=1 with the header at M+1.
- Minimum command-to-header latency: 2 cycles.
- With TX_READY_I tied high, one byte is transferred per cycle. The last byte is accepted at M+1+NB; CMD_READY_O=1 at M+2+NB.
- Back-to-back commands: one idle cycle minimum between the last TX byte and the next command acceptance.

## Configuration
- Macro: TAP_READ_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each READ cycle while READ_VALID_I=0.
  - When the count reaches TIMEOUT_CYCLES without READ_VALID_I, the next cycle drops READ_READY_O, sets the error flag, zeroes the data shift register and enters SEND.
  - The frame is then header bit7=1 followed by NB bytes of 0x00.
  - If READ_VALID_I=1 in the same cycle as expiry, the valid data wins and no error is flagged.
- Undefined: no counter exists, the error flag is constant 0, and READ waits indefinitely.

## Test plan
- Reset then idle: RST_I high 3 cycles → all outputs 0; CMD_READY_O=1 in the first cycle after release.
- Normal read: CMD_ADDR_I=ADDR_IDCODE, READ_VALID_I=1 immediately, READ_DATA_I=0x1234_5678, TX_READY_I=1 → TX bytes header(ADDR_IDCODE), 0x78, 0x56, 0x34, 0x12 on consecutive cycles; header at accept+2.
- Delayed valid with TX backpressure: READ_VALID_I asserted 10 cycles after READ_READY_O; TX_READY_I toggles 1/0 → READ_READY_O stays high for exactly 11 cycles; each byte held stable until accepted; 5 bytes total, correct order.
- Command backpressure: CMD_VALID_I held high throughout a transaction → CMD_READY_O=0 until the last byte is accepted plus 1 cycle; second command accepted exactly once.
- Timeout (macro defined, TIMEOUT_CYCLES=16): READ_VALID_I never asserted → READ_READY_O drops after 16 wait cycles; frame is {0x80|addr, 0x00, 0x00, 0x00, 0x00}. Same stimulus with macro undefined → no TX activity after 100 cycles.
- Mid-transaction reset: RST_I pulsed after the 2nd TX byte → TX_VALID_O=0 next cycle, no remaining bytes emitted, fresh command after release produces a full correct frame.

Source files
------------

// File: rtl/tap_read_arbiter.sv
// -----------------------------------------------------------------------------
// uart_pkg / tap_read_arbiter
//
// Purpose:
//   Read sequencing stage in front of the TAP read interconnect. A command
//   carrying a register address is accepted from the UART command decoder.
//   The arbiter then performs a ready/valid read against the interconnect and
//   captures the returned word. It sends the result to the UART transmitter
//   as a framed byte stream: one header byte, then NB data bytes, least
//   significant byte first.
//
// Header byte: bit7 = error flag, bits[6:IRLENGTH] = 0,
//              bits[IRLENGTH-1:0] = address.
//
// Optional feature (macro TAP_READ_ARBITER_TIMEOUT_EN):
//   Defined   - READ gives up after TIMEOUT_CYCLES cycles without READ_VALID_I.
//               It then sends a frame with the error bit set and all data
//               bytes zero.
//   Undefined - READ waits indefinitely and the error bit is always 0.
//
// Parameters:
//   READ_WIDTH      width of the read word; NB = ceil(READ_WIDTH/8)
//   TIMEOUT_CYCLES  READ wait limit when the timeout is compiled in (>= 1)
//
// Ports:
//   CLK_I, RST_I           clock, synchronous active-high reset
//   CMD_VALID_I/READY_O    command handshake, CMD_ADDR_I = register address
//   READ_ADDRESS_O         address presented to the interconnect
//   READ_READY_O           read request/ready to the interconnect
//   READ_VALID_I/DATA_I    interconnect response
//   TX_DATA_O/VALID_O      byte stream to the UART transmitter
//   TX_READY_I             transmitter accepts the current byte
//   BUSY_O                 high whenever the arbiter is not idle
//
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------

package uart_pkg;
  localparam int unsigned           IRLENGTH    = 5;
  localparam logic [IRLENGTH-1:0]   ADDR_IDCODE = 5'h01;
endpackage

module tap_read_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned READ_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CMD_VALID_I,
  output logic                  CMD_READY_O,
  input  logic [IRLENGTH-1:0]   CMD_ADDR_I,
  output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
  output logic                  READ_READY_O,
  input  logic                  READ_VALID_I,
  input  logic [READ_WIDTH-1:0] READ_DATA_I,
  output logic [7:0]            TX_DATA_O,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic                  BUSY_O
);

  localparam int unsigned NB = (READ_WIDTH + 7) / 8;
  localparam int unsigned SW = NB * 8;
  localparam int unsigned IW = $clog2(NB + 1);

  // Elaboration-time parameter sanity checks.
  if (IRLENGTH > 7) begin : g_bad_irlength
    $error("tap_read_arbiter: IRLENGTH must be <= 7");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("tap_read_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IRLENGTH-1:0] addr_q, addr_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                read_ready_q, read_ready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                busy_q, busy_d;

  // Asserted in the READ cycle in which the wait limit expires.
  logic                timeout_hit;

  function automatic logic [7:0] make_header(input logic                err,
                                             input logic [IRLENGTH-1:0] addr);
    logic [7:0] h;
    h                 = '0;
    h[IRLENGTH-1:0]   = addr;
    h[7]              = err;
    return h;
  endfunction

`ifdef TAP_READ_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter is held at zero outside READ, so it always starts fresh at
  // command accept. It counts READ cycles without valid. Expiry occurs on the
  // TIMEOUT_CYCLES-th such cycle, so READ_READY_O stays high for exactly
  // TIMEOUT_CYCLES cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != READ) begin
      cnt_d = '0;
    end else if (!READ_VALID_I) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == READ) && !READ_VALID_I &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    cmd_ready_d  = cmd_ready_q;
    read_ready_d = read_ready_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        // Ready goes high one cycle after reset release and stays high while idle.
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_ready_q && CMD_VALID_I) begin
          addr_d       = CMD_ADDR_I;
          state_d      = READ;
          cmd_ready_d  = 1'b0;
          read_ready_d = 1'b1;
          busy_d       = 1'b1;
        end
      end

      READ: begin
        // Valid data has priority over a timeout in the same cycle.
        if (READ_VALID_I) begin
          shift_d                 = '0;
          shift_d[READ_WIDTH-1:0] = READ_DATA_I;
          idx_d                   = '0;
          read_ready_d            = 1'b0;
          tx_valid_d              = 1'b1;
          tx_data_d               = make_header(1'b0, addr_q);
          state_d                 = SEND;
        end else if (timeout_hit) begin
          shift_d      = '0;
          idx_d        = '0;
          read_ready_d = 1'b0;
          tx_valid_d   = 1'b1;
          tx_data_d    = make_header(1'b1, addr_q);
          state_d      = SEND;
        end
      end

      SEND: begin
        // tx_valid_q is always high in SEND. The low byte of the shift
        // register is the next byte to present, so the data goes out LSB
        // first.
        if (TX_READY_I) begin
          if (idx_q == IW'(NB)) begin
            state_d     = IDLE;
            tx_valid_d  = 1'b0;
            tx_data_d   = '0;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 8;
          end
        end
      end

      default: begin
        state_d      = IDLE;
        cmd_ready_d  = 1'b0;
        read_ready_d = 1'b0;
        tx_valid_d   = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      cmd_ready_q  <= 1'b0;
      read_ready_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      cmd_ready_q  <= cmd_ready_d;
      read_ready_q <= read_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
    end
  end

  assign CMD_READY_O    = cmd_ready_q;
  assign READ_ADDRESS_O = addr_q;
  assign READ_READY_O   = read_ready_q;
  assign TX_VALID_O     = tx_valid_q;
  assign TX_DATA_O      = tx_data_q;
  assign BUSY_O         = busy_q;

endmodule
